// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the four-point negacyclic NTT pair over q = 7681.
package ntt_pkg;

    localparam int unsigned W = 17;

    localparam logic [W-1:0] Q        = 17'd7681;
    localparam logic [W-1:0] PSI      = 17'd1925;
    localparam logic [W-1:0] PSI2     = 17'd3383;
    localparam logic [W-1:0] PSI3     = 17'd6468;
    localparam logic [W-1:0] PSI_INV  = 17'd1213;
    localparam logic [W-1:0] PSI_INV2 = 17'd4298;
    localparam logic [W-1:0] PSI_INV3 = 17'd5756;
    localparam logic [W-1:0] N_INV    = 17'd5761;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BF1   = 3'd1,
        MUL1  = 3'd2,
        BF2   = 3'd3,
        MUL2  = 3'd4,
        SCALE = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/four_point_intt_mod_mul_q.sv
// Combinational modular multiplier: (a * b) mod Q on a full-width product.
module mod_mul_q
    import ntt_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] p_o
);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    assign p_o  = W'(prod % {{W{1'b0}}, Q});

endmodule

// File: rtl/four_point_intt.sv
// Four-point negacyclic inverse NTT (Gentleman-Sande) with one shared multiplier.
// Working registers r0..r3 are updated in place: y -> t/d -> z/e -> z.
module four_point_intt
    import ntt_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3
);

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] r_q   [4];
    logic [W-1:0] r_d   [4];
    logic [W-1:0] out_q [4];
    logic [W-1:0] out_d [4];
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] mul_a, mul_b, mul_p;

    function automatic logic [W-1:0] add_q(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? (a + Q - b) : (a - b);
    endfunction

    mod_mul_q u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = BF1;
            BF1:   begin state_d = MUL1; cnt_d = 2'd0; end
            MUL1:  if (cnt_q == 2'd1) begin state_d = BF2; cnt_d = 2'd0; end
                   else cnt_d = cnt_q + 2'd1;
            BF2:   begin state_d = MUL2; cnt_d = 2'd0; end
            MUL2:  if (cnt_q == 2'd1) begin state_d = SCALE; cnt_d = 2'd0; end
                   else cnt_d = cnt_q + 2'd1;
            SCALE: if (cnt_q == 2'd3) begin state_d = DONE; cnt_d = 2'd0; end
                   else cnt_d = cnt_q + 2'd1;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; multiplier operands are muxed per step
    always_comb begin
        r_d         = r_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        mul_a       = r_q[0];
        mul_b       = N_INV;
        case (state_q)
            IDLE: if (in_valid) begin
                r_d[0] = in0 % Q;
                r_d[1] = in1 % Q;
                r_d[2] = in2 % Q;
                r_d[3] = in3 % Q;
            end
            BF1: begin
                r_d[0] = add_q(r_q[0], r_q[1]);
                r_d[1] = sub_q(r_q[0], r_q[1]);
                r_d[2] = add_q(r_q[2], r_q[3]);
                r_d[3] = sub_q(r_q[2], r_q[3]);
            end
            MUL1: begin
                mul_a = cnt_q[0] ? r_q[3] : r_q[1];
                mul_b = cnt_q[0] ? PSI_INV3 : PSI_INV;
                if (cnt_q[0]) r_d[3] = mul_p;
                else          r_d[1] = mul_p;
            end
            BF2: begin
                r_d[0] = add_q(r_q[0], r_q[2]);
                r_d[2] = sub_q(r_q[0], r_q[2]);
                r_d[1] = add_q(r_q[1], r_q[3]);
                r_d[3] = sub_q(r_q[1], r_q[3]);
            end
            MUL2: begin
                mul_a = cnt_q[0] ? r_q[3] : r_q[2];
                mul_b = PSI_INV2;
                if (cnt_q[0]) r_d[3] = mul_p;
                else          r_d[2] = mul_p;
            end
            SCALE: begin
                mul_a        = r_q[cnt_q];
                mul_b        = N_INV;
                out_d[cnt_q] = mul_p;
                if (cnt_q == 2'd3) out_valid_d = 1'b1;
            end
            DONE: if (out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_q[i]   <= '0;
                out_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];

endmodule

// File: tb/tb_four_point_intt.sv
// Self-checking bench for four_point_intt: directed vectors plus randomized round trips
// through a plain-arithmetic forward NTT model.
module tb_four_point_intt;

    localparam int unsigned W  = 17;
    localparam int          QM = 7681;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in0, in1, in2, in3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out0, out1, out2, out3;

    int total = 0;
    int bad   = 0;

    four_point_intt dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic int mulm(input int a, input int b);
        return int'((longint'(a) * longint'(b)) % longint'(QM));
    endfunction

    function automatic int powm(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = mulm(r, b);
        return r;
    endfunction

    // Forward negacyclic NTT in the order A(psi), A(psi^5), A(psi^3), A(psi^7)
    task automatic fwd(input int x [4], output int y [4]);
        int ex [4];
        ex = '{1, 5, 3, 7};
        for (int k = 0; k < 4; k++) begin
            y[k] = 0;
            for (int j = 0; j < 4; j++)
                y[k] = (y[k] + mulm(x[j], powm(1925, ex[k] * j))) % QM;
        end
    endtask

    task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] a2, input logic [W-1:0] a3,
                        input bit rand_rdy, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_to_accept", 32'(in_ready), 1);
        in0 = a0; in1 = a1; in2 = a2; in3 = a3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
        lat = 0;
        do begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] e [4]);
        check({tag, "_out0"}, 32'(out0), 32'(e[0]));
        check({tag, "_out1"}, 32'(out1), 32'(e[1]));
        check({tag, "_out2"}, 32'(out2), 32'(e[2]));
        check({tag, "_out3"}, 32'(out3), 32'(e[3]));
    endtask

    task automatic finish_hs(input bit rand_rdy, input logic [W-1:0] e [4]);
        bit hs;
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < 40) begin
            hs = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = hs;
            @(posedge clk); #1;
            n++;
            if (hs) done = 1'b1;
            else begin
                check("hold_valid", 32'(out_valid), 1);
                check_outs("hold", e);
            end
        end
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 0);
        check("post_hs_ready", 32'(in_ready), 1);
    endtask

    task automatic do_xform(input logic [W-1:0] a0, input logic [W-1:0] a1,
                            input logic [W-1:0] a2, input logic [W-1:0] a3,
                            input bit rand_rdy, input logic [W-1:0] e [4]);
        int lat;
        send(a0, a1, a2, a3, rand_rdy, lat);
        check("latency", 32'(lat), 10);
        check_outs("result", e);
        finish_hs(rand_rdy, e);
    endtask

    initial begin
        logic [W-1:0] e [4];
        int x [4];
        int y [4];
        int lat;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e = '{17'd0, 17'd0, 17'd0, 17'd0};
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 1);
        check_outs("rst", e);

        e = '{17'd1, 17'd0, 17'd0, 17'd0};
        do_xform(17'd1, 17'd1, 17'd1, 17'd1, 1'b0, e);

        e = '{17'd0, 17'd1, 17'd0, 17'd0};
        do_xform(17'd1925, 17'd5756, 17'd6468, 17'd1213, 1'b0, e);

        e = '{17'd5, 17'd0, 17'd0, 17'd0};
        do_xform(17'd5, 17'd5, 17'd5, 17'd5, 1'b0, e);

        e = '{17'd0, 17'd0, 17'd0, 17'd0};
        do_xform(17'd7681, 17'd7681, 17'd7681, 17'd7681, 1'b0, e);

        // Backpressure: DONE held for six cycles while in_valid toggles
        e = '{17'd0, 17'd1, 17'd0, 17'd0};
        send(17'd1925, 17'd5756, 17'd6468, 17'd1213, 1'b0, lat);
        check("bp_latency", 32'(lat), 10);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            in0 = 17'd999; in1 = 17'd3; in2 = 17'd77; in3 = 17'd4000;
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_ready", 32'(in_ready), 0);
            check_outs("bp", e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_ready", 32'(in_ready), 1);
        check_outs("bp_keep", e);
        e = '{17'd5, 17'd0, 17'd0, 17'd0};
        do_xform(17'd5, 17'd5, 17'd5, 17'd5, 1'b0, e);

        // Reset while in MUL2 aborts the transform
        send_abort();
        e = '{17'd0, 17'd0, 17'd0, 17'd0};
        check("abort_valid", 32'(out_valid), 0);
        check("abort_ready", 32'(in_ready), 1);
        check_outs("abort", e);
        e = '{17'd1, 17'd0, 17'd0, 17'd0};
        do_xform(17'd1, 17'd1, 17'd1, 17'd1, 1'b0, e);

        // Round trip through the forward model, inputs offset by random multiples of Q
        for (int t = 0; t < 200; t++) begin
            for (int k = 0; k < 4; k++) x[k] = int'($urandom_range(0, QM - 1));
            fwd(x, y);
            for (int k = 0; k < 4; k++) begin
                y[k] = y[k] + QM * int'($urandom_range(0, 15));
                e[k] = W'(x[k]);
            end
            do_xform(W'(y[0]), W'(y[1]), W'(y[2]), W'(y[3]), 1'b1, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic send_abort();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_accept_ready", 32'(in_ready), 1);
        in0 = 17'd2; in1 = 17'd3; in2 = 17'd4; in3 = 17'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort_busy", 32'(in_ready), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

endmodule
